// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and start/busy issue controller feeding the UART transmitter
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_ok;
  logic              pop;
  logic              tx_start_next;
  logic [ADDR_W:0]   count_next;

  // full is the registered flag, so a write racing a pop on a full FIFO is still dropped
  assign wr_ok = wr_en && !full;

  always_comb begin
    count_next = count;
    if (wr_ok && !pop) begin
      count_next = count + 1'b1;
    end else if (!wr_ok && pop) begin
      count_next = count - 1'b1;
    end
  end

  always_comb begin
    state_next    = state;
    pop           = 1'b0;
    tx_start_next = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0 && !tx_busy) begin
          pop           = 1'b1;
          tx_start_next = 1'b1;
          state_next    = LAUNCH;
        end
      end
      LAUNCH: begin
        // start stays high until the transmitter shows busy; no timeout by design
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else begin
          tx_start_next = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state    <= state_next;
      count    <= count_next;
      full     <= (count_next == FULL_COUNT);
      empty    <= (count_next == '0);
      overflow <= wr_en && full;
      tx_start <= tx_start_next;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with transmitter model and scoreboard
module tb_uart_tx_fifo;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_en = 1'b0;
  logic [7:0]        wr_data = 8'h00;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              tx_busy;
  logic              tx_start;
  logic [7:0]        tx_data;

  logic              mbusy = 1'b0;
  logic              force_busy = 1'b0;
  logic              model_on = 1'b0;
  int                frame_len = 4;
  int                frame_cnt = 0;
  logic [7:0]        rx_mem [0:1023];
  int                rx_n = 0;
  int                rx_rd = 0;

  logic [7:0]        exp_q [$];
  int                m_count = 0;
  logic              ovf_exp = 1'b0;
  logic              start_prev = 1'b0;
  logic              last_acc = 1'b0;
  logic              last_pop = 1'b0;
  int                total = 0;
  int                bad = 0;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data)
  );

  always #5 clk = ~clk;

  // transmitter: accepts on start && !busy, busy rises the following cycle
  assign tx_busy = mbusy | force_busy;

  always @(posedge clk) begin
    if (model_on && tx_start && !tx_busy) begin
      rx_mem[rx_n] <= tx_data;
      rx_n         <= rx_n + 1;
      mbusy        <= 1'b1;
      frame_cnt    <= frame_len;
    end else if (mbusy) begin
      if (frame_cnt == 0) mbusy <= 1'b0;
      else frame_cnt <= frame_cnt - 1;
    end
  end

  // one clock; updates the occupancy reference and scoreboard from the inputs applied this cycle
  task automatic tick();
    logic w, r, fm;
    logic [7:0] d;
    w  = wr_en;
    d  = wr_data;
    r  = reset;
    fm = (m_count == DEPTH);
    @(posedge clk);
    #1;
    if (r) begin
      m_count    = 0;
      exp_q.delete();
      ovf_exp    = 1'b0;
      start_prev = 1'b0;
      last_acc   = 1'b0;
      last_pop   = 1'b0;
      rx_rd      = rx_n;
    end else begin
      ovf_exp  = w && fm;
      last_acc = w && !fm;
      last_pop = tx_start && !start_prev;
      if (last_acc) begin
        exp_q.push_back(d);
        m_count++;
      end
      if (last_pop) m_count--;
      start_prev = tx_start;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wr_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d expected=0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b expected=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b expected=0", full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b expected=0", overflow); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start got=%b expected=0", tx_start); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h expected=00", tx_data); end
  endtask

  task automatic test_single();
    logic [7:0] e;
    int n;
    model_on   = 1'b1;
    force_busy = 1'b0;
    frame_len  = 5;
    wr_data = 8'hA5;
    wr_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    total++; if (count !== 5'd1) begin bad++; $display("FAIL single_count1 got=%0d expected=1", count); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL single_start_early got=%b expected=0", tx_start); end
    tick();
    total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL single_start got=%b expected=1", tx_start); end
    total++; if (tx_data !== 8'hA5) begin bad++; $display("FAIL single_data got=%h expected=a5", tx_data); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL single_count0 got=%0d expected=0", count); end
    n = 0;
    while (tx_busy !== 1'b1 && n < 20) begin tick(); n++; end
    total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL single_busy_wait got=%b expected=1", tx_busy); end
    tick();
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL single_start_fall got=%b expected=0", tx_start); end
    for (int i = 0; i < 400 && (exp_q.size() != 0 || rx_rd != rx_n); i++) begin
      tick();
      while (rx_rd < rx_n) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL single_extra got=%h expected=none", rx_mem[rx_rd]); end
        else begin e = exp_q.pop_front(); if (rx_mem[rx_rd] !== e) begin bad++; $display("FAIL single_order got=%h expected=%h", rx_mem[rx_rd], e); end end
        rx_rd++;
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL single_drain left=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_burst();
    logic [7:0] e;
    force_busy = 1'b1;
    model_on   = 1'b1;
    frame_len  = 3;
    tick();
    for (int i = 1; i <= 16; i++) begin
      wr_data = 8'(i);
      wr_en   = 1'b1;
      tick();
      total++; if (count !== 5'(m_count)) begin bad++; $display("FAIL burst_count got=%0d expected=%0d", count, m_count); end
    end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL burst_full got=%b expected=1", full); end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL burst_count16 got=%0d expected=16", count); end
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL burst_empty got=%b expected=0", empty); end
    wr_data = 8'hFF;
    tick();
    wr_en = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL burst_overflow got=%b expected=1", overflow); end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL burst_count_ovf got=%0d expected=16", count); end
    tick();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL burst_overflow_pulse got=%b expected=0", overflow); end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL burst_count_hold got=%0d expected=16", count); end
    force_busy = 1'b0;
    for (int i = 0; i < 800 && (exp_q.size() != 0 || rx_rd != rx_n); i++) begin
      tick();
      while (rx_rd < rx_n) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL burst_extra got=%h expected=none", rx_mem[rx_rd]); end
        else begin e = exp_q.pop_front(); if (rx_mem[rx_rd] !== e) begin bad++; $display("FAIL burst_order got=%h expected=%h", rx_mem[rx_rd], e); end end
        rx_rd++;
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL burst_drain left=%0d expected=0", exp_q.size()); end
    repeat (12) tick();
    total++; if (rx_n != rx_rd) begin bad++; $display("FAIL burst_no_extra got=%0d expected=%0d", rx_n, rx_rd); end
  endtask

  task automatic test_continuous();
    logic [7:0] e;
    logic [7:0] seq;
    int acc, coinc, prev;
    force_busy = 1'b0;
    model_on   = 1'b1;
    frame_len  = 2;
    seq   = 8'h40;
    acc   = 0;
    coinc = 0;
    wr_en = 1'b1;
    for (int i = 0; i < 1000 && acc < 40; i++) begin
      wr_data = seq;
      seq++;
      prev = m_count;
      tick();
      if (last_acc) acc++;
      if (last_acc && last_pop) begin
        coinc++;
        total++; if (count !== 5'(prev)) begin bad++; $display("FAIL cont_coincident got=%0d expected=%0d", count, prev); end
      end
      total++; if (count !== 5'(m_count)) begin bad++; $display("FAIL cont_count got=%0d expected=%0d", count, m_count); end
      total++; if (overflow !== ovf_exp) begin bad++; $display("FAIL cont_overflow got=%b expected=%b", overflow, ovf_exp); end
      while (rx_rd < rx_n) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL cont_extra got=%h expected=none", rx_mem[rx_rd]); end
        else begin e = exp_q.pop_front(); if (rx_mem[rx_rd] !== e) begin bad++; $display("FAIL cont_order got=%h expected=%h", rx_mem[rx_rd], e); end end
        rx_rd++;
      end
    end
    wr_en = 1'b0;
    total++; if (acc != 40) begin bad++; $display("FAIL cont_accepted got=%0d expected=40", acc); end
    total++; if (coinc == 0) begin bad++; $display("FAIL cont_coincident_seen got=%0d expected=nonzero", coinc); end
    for (int i = 0; i < 800 && (exp_q.size() != 0 || rx_rd != rx_n); i++) begin
      tick();
      while (rx_rd < rx_n) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL cont_extra got=%h expected=none", rx_mem[rx_rd]); end
        else begin e = exp_q.pop_front(); if (rx_mem[rx_rd] !== e) begin bad++; $display("FAIL cont_order got=%h expected=%h", rx_mem[rx_rd], e); end end
        rx_rd++;
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL cont_drain left=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_idle();
    int starts, nonempty;
    repeat (12) tick();
    starts   = 0;
    nonempty = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx_start !== 1'b0) starts++;
      if (empty !== 1'b1) nonempty++;
    end
    total++; if (starts != 0) begin bad++; $display("FAIL idle_tx_start got=%0d expected=0", starts); end
    total++; if (nonempty != 0) begin bad++; $display("FAIL idle_empty got=%0d expected=0", nonempty); end
  endtask

  task automatic test_reset_launch();
    logic [7:0] e;
    int n;
    model_on   = 1'b0;
    force_busy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'hB0 + 8'(i);
      wr_en   = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    n = 0;
    while (tx_start !== 1'b1 && n < 20) begin tick(); n++; end
    tick();
    tick();
    total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL rl_launch got=%b expected=1", tx_start); end
    total++; if (count !== 5'd5) begin bad++; $display("FAIL rl_count5 got=%0d expected=5", count); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rl_tx_start got=%b expected=0", tx_start); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL rl_count got=%0d expected=0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL rl_empty got=%b expected=1", empty); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rl_tx_data got=%h expected=00", tx_data); end
    model_on = 1'b1;
    wr_data  = 8'h3C;
    wr_en    = 1'b1;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 400 && (exp_q.size() != 0 || rx_rd != rx_n); i++) begin
      tick();
      while (rx_rd < rx_n) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL rl_extra got=%h expected=none", rx_mem[rx_rd]); end
        else begin e = exp_q.pop_front(); if (rx_mem[rx_rd] !== e) begin bad++; $display("FAIL rl_order got=%h expected=%h", rx_mem[rx_rd], e); end end
        rx_rd++;
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rl_drain left=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_busy_hold();
    logic [7:0] e;
    int n, starts;
    model_on   = 1'b1;
    force_busy = 1'b0;
    frame_len  = 4;
    repeat (15) tick();
    wr_data = 8'h51;
    wr_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    n = 0;
    while (!(tx_busy === 1'b1 && tx_start === 1'b0) && n < 30) begin tick(); n++; end
    total++; if (tx_busy !== 1'b1 || tx_start !== 1'b0) begin bad++; $display("FAIL hold_wait_done busy=%b start=%b expected busy=1 start=0", tx_busy, tx_start); end
    force_busy = 1'b1;
    starts = 0;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'h52 + 8'(i);
      wr_en   = 1'b1;
      tick();
      if (tx_start !== 1'b0) starts++;
    end
    wr_en = 1'b0;
    repeat (20) begin
      tick();
      if (tx_start !== 1'b0) starts++;
    end
    total++; if (starts != 0) begin bad++; $display("FAIL hold_no_start got=%0d expected=0", starts); end
    total++; if (count !== 5'd4) begin bad++; $display("FAIL hold_count got=%0d expected=4", count); end
    force_busy = 1'b0;
    for (int i = 0; i < 400 && (exp_q.size() != 0 || rx_rd != rx_n); i++) begin
      tick();
      while (rx_rd < rx_n) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL hold_extra got=%h expected=none", rx_mem[rx_rd]); end
        else begin e = exp_q.pop_front(); if (rx_mem[rx_rd] !== e) begin bad++; $display("FAIL hold_order got=%h expected=%h", rx_mem[rx_rd], e); end end
        rx_rd++;
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL hold_drain left=%0d expected=0", exp_q.size()); end
    repeat (12) tick();
    total++; if (rx_n != rx_rd) begin bad++; $display("FAIL hold_no_extra got=%0d expected=%0d", rx_n, rx_rd); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_continuous();
    test_idle();
    test_reset_launch();
    test_busy_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
